// File: rtl/ahbl_regfile_ws.sv
// AHB-Lite slave register file: a read-only ID word at offset 0 followed by
// NREGS read/write 32-bit registers, with a fixed number of wait states on
// every OKAY data phase and the standard two-cycle ERROR response.
module ahbl_regfile_ws #(
    parameter logic [31:0] ID          = 32'hABCD_EF00,
    parameter int          NREGS       = 4,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR1,
        ERR2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  cnt_next;
    logic        dp_valid;
    logic        dp_next;
    logic [7:0]  lat_addr;
    logic        lat_write;
    logic [2:0]  lat_size;
    logic        accept;
    logic        addr_err;
    logic        complete;
    logic        commit;
    logic [5:0]  lat_idx;
    logic [3:0]  byte_en;
    logic [31:0] rd_word;
    logic [31:0] regs [NREGS];
    logic        unused_bits;

    // Upper address bits and HTRANS[0] carry no meaning for this slave.
    assign unused_bits = ^{HADDR[31:8], HTRANS[0]};

    // A new address phase is only taken when the previous one is finishing.
    assign accept   = HSEL && HTRANS[1] && HREADY && (state == IDLE || state == ERR2);
    assign lat_idx  = lat_addr[7:2];
    assign complete = (state == IDLE) && dp_valid;
    assign commit   = complete && lat_write;

    // Classify the incoming address phase as an error response or not.
    always_comb begin
        addr_err = 1'b0;
        if (HADDR[7:2] > 6'(NREGS))                     addr_err = 1'b1;
        if (HWRITE && HADDR[7:2] == 6'd0)               addr_err = 1'b1;
        if (HSIZE > 3'd2)                               addr_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])                  addr_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)       addr_err = 1'b1;
    end

    // Next-state and response outputs of the transfer FSM.
    always_comb begin
        state_next = state;
        cnt_next   = wait_cnt;
        dp_next    = dp_valid;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        case (state)
            IDLE, ERR2: begin
                if (state == ERR2) begin
                    HRESP = 1'b1;
                end
                state_next = IDLE;
                cnt_next   = 4'd0;
                dp_next    = 1'b0;
                if (accept) begin
                    if (addr_err) begin
                        state_next = ERR1;
                    end else begin
                        dp_next = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_next = WAIT;
                            cnt_next   = 4'(WAIT_STATES);
                        end
                    end
                end
            end
            WAIT: begin
                HREADYOUT = 1'b0;
                cnt_next  = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_next = IDLE;
                end
            end
            ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ERR2;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, wait counter and address/control capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            dp_valid  <= 1'b0;
            lat_addr  <= 8'd0;
            lat_write <= 1'b0;
            lat_size  <= 3'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
            dp_valid <= dp_next;
            if (accept) begin
                lat_addr  <= HADDR[7:0];
                lat_write <= HWRITE;
                lat_size  <= HSIZE;
            end
        end
    end

    // Little-endian byte lanes touched by the latched write.
    always_comb begin
        byte_en = 4'b0000;
        case (lat_size)
            3'd0:    byte_en[lat_addr[1:0]] = 1'b1;
            3'd1:    byte_en = lat_addr[1] ? 4'b1100 : 4'b0011;
            3'd2:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Register storage; writes land on the edge that completes the data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (lat_idx == 6'(i + 1)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byte_en[b]) begin
                            regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Full word at the latched index; index 0 is the ID word.
    always_comb begin
        rd_word = ID;
        for (int i = 0; i < NREGS; i++) begin
            if (lat_idx == 6'(i + 1)) begin
                rd_word = regs[i];
            end
        end
    end

    // Read data is driven only in the completing cycle of an OKAY read.
    always_comb begin
        HRDATA = 32'd0;
        if (complete && !lat_write) begin
            HRDATA = rd_word;
        end
    end

endmodule
